// File: rtl/clock_period_monitor.sv
// Measures period and high time of a slow probe clock in clock_in cycles, declares lock on a run of
// matching periods, and flags mismatches while locked and stalls. Define DUTY_CHECK_EN to also require 50% duty.
module clock_period_monitor #(
  parameter int CNT_W         = 16,
  parameter int EXPECTED_HALF = 4,
  parameter int LOCK_COUNT    = 4
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             clock_probe,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             err,
  output logic             stall
);

  localparam int     MC_W    = $clog2(LOCK_COUNT + 1);
  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  function automatic logic [CNT_W-1:0] clamp_cnt(input longint v);
    if (v > CNT_MAX) return '1;
    return v[CNT_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A threshold beyond the counter range is pulled down to the saturation value so the timeout still fires.
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = clamp_cnt(4 * longint'(EXPECTED_HALF));
  localparam logic [CNT_W-1:0] MATCH_VAL   = clamp_cnt(2 * longint'(EXPECTED_HALF));
  localparam bit               MATCH_OK    = (2 * longint'(EXPECTED_HALF) <= CNT_MAX);
`ifdef DUTY_CHECK_EN
  localparam logic [CNT_W-1:0] HALF_VAL    = clamp_cnt(longint'(EXPECTED_HALF));
`endif

  typedef enum logic [1:0] {IDLE, MEASURE, TRACK, LOCKED} state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q, hist_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [MC_W-1:0]  match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             mv_q, mv_d;
  logic             err_q, err_d;
  logic             stall_q, stall_d;
`ifdef DUTY_CHECK_EN
  logic             fell_q, fell_d;
`endif

  logic rise, fall, match, timeout;

  assign rise = sync2_q & ~hist_q;
  assign fall = ~sync2_q & hist_q;

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      hist_q      <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      match_cnt_q <= '0;
      period_q    <= '0;
      high_q      <= '0;
      mv_q        <= 1'b0;
      err_q       <= 1'b0;
      stall_q     <= 1'b0;
`ifdef DUTY_CHECK_EN
      fell_q      <= 1'b0;
`endif
    end else begin
      sync1_q     <= clock_probe;
      sync2_q     <= sync1_q;
      hist_q      <= sync2_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      match_cnt_q <= match_cnt_d;
      period_q    <= period_d;
      high_q      <= high_d;
      mv_q        <= mv_d;
      err_q       <= err_d;
      stall_q     <= stall_d;
`ifdef DUTY_CHECK_EN
      fell_q      <= fell_d;
`endif
    end
  end

  always_comb begin
    cnt_d    = rise ? CNT_W'(1) : sat_inc(cnt_q);
    high_d   = (fall && state_q != IDLE) ? cnt_q : high_q;
    period_d = period_q;
    mv_d     = 1'b0;
    if (rise && state_q != IDLE) begin
      period_d = cnt_q;
      mv_d     = 1'b1;
    end

`ifdef DUTY_CHECK_EN
    // high_q holds this period's high time only if a fall was seen since the last rise.
    fell_d = rise ? 1'b0 : ((fall && state_q != IDLE) ? 1'b1 : fell_q);
    match  = MATCH_OK && (cnt_q == MATCH_VAL) && fell_q && (high_q == HALF_VAL);
`else
    match  = MATCH_OK && (cnt_q == MATCH_VAL);
`endif

    timeout     = (state_q != IDLE) && (cnt_q == TIMEOUT_VAL) && !rise;
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    err_d       = err_q;
    stall_d     = stall_q;

    if (timeout) begin
      state_d     = IDLE;
      stall_d     = 1'b1;
      match_cnt_d = '0;
    end else if (rise) begin
      case (state_q)
        IDLE: begin
          state_d = MEASURE;
          stall_d = 1'b0;
        end
        MEASURE: begin
          state_d     = TRACK;
          match_cnt_d = match ? MC_W'(1) : '0;
        end
        TRACK: begin
          if (!match) begin
            match_cnt_d = '0;
          end else if (match_cnt_q == MC_W'(LOCK_COUNT - 1)) begin
            state_d     = LOCKED;
            match_cnt_d = MC_W'(LOCK_COUNT);
          end else begin
            match_cnt_d = match_cnt_q + 1'b1;
          end
        end
        LOCKED: begin
          if (!match) begin
            state_d     = TRACK;
            err_d       = 1'b1;
            match_cnt_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    locked     = (state_q == LOCKED);
    period     = period_q;
    high_time  = high_q;
    meas_valid = mv_q;
    err        = err_q;
    stall      = stall_q;
  end

endmodule

// File: tb/tb_clock_period_monitor.sv
// Directed table-driven bench for clock_period_monitor at default parameters (DUTY_CHECK_EN undefined).
module tb_clock_period_monitor;

  localparam int CNT_W = 16;

  logic             clock_in;
  logic             reset;
  logic             clock_probe;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             locked;
  logic             err;
  logic             stall;

  clock_period_monitor #(.CNT_W(CNT_W), .EXPECTED_HALF(4), .LOCK_COUNT(4)) dut (
    .clock_in   (clock_in),
    .reset      (reset),
    .clock_probe(clock_probe),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .locked     (locked),
    .err        (err),
    .stall      (stall)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  typedef struct {
    int hi;
    int lo;
    bit mv;
    int per;
    int ht;
    bit lk;
    bit er;
    bit st;
  } vec_t;

  vec_t tbl[22];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic row(input int i, input int hi, input int lo, input bit mv, input int per,
                     input int ht, input bit lk, input bit er);
    tbl[i] = '{hi: hi, lo: lo, mv: mv, per: per, ht: ht, lk: lk, er: er, st: 1'b0};
  endtask

  // Drives one probe period (hi >= 3) and checks the outputs right after its opening rise is detected.
  task automatic run_vec(input int i);
    @(posedge clock_in);
    #1 clock_probe = 1'b1;
    repeat (3) @(posedge clock_in);
    @(negedge clock_in);
    chk($sformatf("row%0d.meas_valid", i), meas_valid, tbl[i].mv);
    if (tbl[i].mv) begin
      chk($sformatf("row%0d.period", i), period, tbl[i].per);
      chk($sformatf("row%0d.high_time", i), high_time, tbl[i].ht);
    end
    chk($sformatf("row%0d.locked", i), locked, tbl[i].lk);
    chk($sformatf("row%0d.err", i), err, tbl[i].er);
    chk($sformatf("row%0d.stall", i), stall, tbl[i].st);
    repeat (tbl[i].hi - 3) @(posedge clock_in);
    #1 clock_probe = 1'b0;
    repeat (tbl[i].lo - 1) @(posedge clock_in);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".period"}, period, 0);
    chk({tag, ".high_time"}, high_time, 0);
    chk({tag, ".meas_valid"}, meas_valid, 0);
    chk({tag, ".locked"}, locked, 0);
    chk({tag, ".err"}, err, 0);
    chk({tag, ".stall"}, stall, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Lock, stretched period, relock, 3/5 duty accepted on period alone
    row(0, 4, 4, 0, 0, 0, 0, 0);
    row(1, 4, 4, 1, 8, 4, 0, 0);
    row(2, 4, 4, 1, 8, 4, 0, 0);
    row(3, 4, 4, 1, 8, 4, 0, 0);
    row(4, 4, 4, 1, 8, 4, 1, 0);
    row(5, 4, 4, 1, 8, 4, 1, 0);
    row(6, 5, 5, 1, 8, 4, 1, 0);
    row(7, 4, 4, 1, 10, 5, 0, 1);
    row(8, 4, 4, 1, 8, 4, 0, 1);
    row(9, 4, 4, 1, 8, 4, 0, 1);
    row(10, 4, 4, 1, 8, 4, 0, 1);
    row(11, 3, 5, 1, 8, 4, 1, 1);
    row(12, 4, 4, 1, 8, 3, 1, 1);
    // Recovery after timeout
    row(13, 4, 4, 0, 0, 0, 0, 1);
    row(14, 4, 4, 1, 8, 4, 0, 1);
    row(15, 4, 4, 1, 8, 4, 0, 1);
    row(16, 4, 4, 1, 8, 4, 0, 1);
    row(17, 4, 4, 1, 8, 4, 1, 1);
    row(18, 4, 4, 1, 8, 4, 1, 1);
    // After a mid-period reset
    row(19, 4, 4, 0, 0, 0, 0, 0);
    row(20, 4, 4, 1, 8, 4, 0, 0);
    row(21, 4, 4, 1, 8, 4, 0, 0);

    reset = 1'b1;
    clock_probe = 1'b0;
    repeat (3) @(posedge clock_in);
    @(negedge clock_in);
    chk_all_zero("reset");
    reset = 1'b0;

    for (int i = 0; i <= 12; i++) run_vec(i);

    // Probe held low: last rise detected 4 edges ago, stall lands 16 edges after that detect.
    repeat (11) @(posedge clock_in);
    @(negedge clock_in);
    chk("pre_timeout.stall", stall, 0);
    chk("pre_timeout.locked", locked, 1);
    chk("pre_timeout.meas_valid", meas_valid, 0);
    @(posedge clock_in);
    @(negedge clock_in);
    chk("timeout.stall", stall, 1);
    chk("timeout.locked", locked, 0);
    chk("timeout.err", err, 1);

    for (int i = 13; i <= 18; i++) run_vec(i);

    #2 reset = 1'b1;
    #1 chk_all_zero("async_reset");
    repeat (2) @(negedge clock_in);
    reset = 1'b0;

    for (int i = 19; i <= 21; i++) run_vec(i);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
